pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central hazard/sequencing controller for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Converts load-use, taken-branch, multi-cycle-EX and MEM-exception requests into per-register stall/flush vectors and a PC redirect.
- Owns a small FSM and latency counter for multi-cycle EX ops (divider).
- All stall/flush/redirect outputs are combinational and act at the next clk edge, matching the synchronous flush semantics of the pipeline registers.

Parameters:
MCYC_LAT, 4, EX multi-cycle op latency in stall cycles (>=1)
CNT_W, 6, counter width (2^CNT_W > MCYC_LAT)
EXC_VEC, 32'h0000_0080, exception handler fetch address

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
id_loaduse  in  1  ID detects load-use hazard
ex_branch  in  1  branch resolved taken in EX
ex_branch_tgt  in  32  branch target
ex_mcyc_start  in  1  EX issues multi-cycle op
mem_exc  in  1  exception raised by instruction in MEM
mem_pc  in  32  PC of instruction in MEM
stall  out  5  hold enable; [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
flush  out  5  bubble insert, same bit map
redirect  out  1  load PC with redirect_pc
redirect_pc  out  32  new fetch address
mcyc_done  out  1  one-cycle pulse: EX result valid
mcyc_kill  out  1  abort in-flight multi-cycle unit
epc  out  32  registered PC of last excepting instruction

Behaviour:
- States: RUN, MCYC, EXC. Reset: state=RUN, cnt=0, epc=0. While rst low, all outputs are 0.
- Priority within a cycle: exception > branch > mcyc_start > loaduse.
- Exception (RUN or MCYC, mem_exc=1):
  - flush=5'b11110 (IF/ID..MEM/WB), stall=0, redirect=1, redirect_pc=EXC_VEC.
  - epc<=mem_pc; next state EXC.
  - If in MCYC: mcyc_kill=1, cnt<=0, no mcyc_done.
- EXC (exactly 1 cycle):
  - mem_exc ignored (no nested exception); stall=0, flush=0, redirect=0.
  - Other requests are evaluated as in RUN.
  - Next state RUN.
- Branch (RUN/EXC, ex_branch=1):
  - flush=5'b00110 (IF/ID, ID/EX), redirect=1, redirect_pc=ex_branch_tgt.
  - Same-cycle id_loaduse and ex_mcyc_start are ignored (wrong path).
- Mcyc start (RUN/EXC, ex_mcyc_start=1):
  - stall=5'b00111, flush[3]=1 (bubble into EX/MEM).
  - cnt<=MCYC_LAT-1; next state MCYC.
  - Same-cycle id_loaduse is ignored (ID already held).
- MCYC:
  - cnt!=0: stall=5'b00111, flush[3]=1, cnt<=cnt-1.
  - cnt==0: mcyc_done=1, stall=0, flush=0; next state RUN.
  - Total frozen cycles = MCYC_LAT, including the start cycle.
  - id_loaduse, ex_branch and ex_mcyc_start are ignored in MCYC.
- Load-use (RUN/EXC, no higher request):
  - stall=5'b00011, flush[2]=1 (bubble into ID/EX).
  - Held for as long as id_loaduse is asserted.
- No request: stall=0, flush=0, redirect=0, redirect_pc=0.
- Invariant: a given bit is never set in both stall and flush.
- Async reset in MCYC aborts to RUN with no mcyc_done; mcyc_kill=0 during reset.

Optional Feature:
PIPE_CTRL_PERF_EN:
- When defined, adds outputs perf_stall_cyc[31:0] and perf_flush_cnt[31:0].
- perf_stall_cyc increments every cycle in which stall[0]=1.
- perf_flush_cnt increments every cycle in which redirect=1.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset low mid-run, then release: all outputs 0 and epc=0. One idle cycle later: stall=0, flush=0, state RUN.
2. id_loaduse high for 2 cycles: stall=5'b00011 and flush=5'b00100 for both cycles; 0 on the third cycle.
3. MCYC_LAT=4, ex_mcyc_start pulse at cycle T: stall=5'b00111 for T..T+3; mcyc_done=1 and stall=0 at T+4.
4. ex_branch=1, ex_branch_tgt=32'h0000_1040, id_loaduse=1 in the same cycle: redirect=1, redirect_pc=32'h0000_1040, flush=5'b00110, stall=0.
5. mem_exc=1, mem_pc=32'h0000_2000 at T+2 of a multi-cycle op: mcyc_kill=1, flush=5'b11110, redirect_pc=32'h0000_0080. Then epc=32'h0000_2000, no mcyc_done, and a mem_exc at T+3 is ignored.
6. With PIPE_CTRL_PERF_EN, run scenarios 2+3+4: perf_stall_cyc=6, perf_flush_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/sequencing controller producing stall/flush/redirect for a 5-stage pipeline.
// Optional perf counters under `PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int          MCYC_LAT = 4,
  parameter int          CNT_W    = 6,
  parameter logic [31:0] EXC_VEC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_loaduse,
  input  logic        ex_branch,
  input  logic [31:0] ex_branch_tgt,
  input  logic        ex_mcyc_start,
  input  logic        mem_exc,
  input  logic [31:0] mem_pc,
  output logic [4:0]  stall,
  output logic [4:0]  flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        mcyc_done,
  output logic        mcyc_kill,
  output logic [31:0] epc
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN, MCYC, EXC} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0] epc_nx, rpc_c;
  logic [4:0] stall_c, flush_c;
  logic redir_c, done_c, kill_c;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
      epc   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      epc   <= epc_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    epc_nx   = epc;
    stall_c  = '0;
    flush_c  = '0;
    redir_c  = 1'b0;
    rpc_c    = '0;
    done_c   = 1'b0;
    kill_c   = 1'b0;
    if (mem_exc && state != EXC) begin
      flush_c  = 5'b11110;
      redir_c  = 1'b1;
      rpc_c    = EXC_VEC;
      epc_nx   = mem_pc;
      state_nx = EXC;
      kill_c   = state == MCYC;
      cnt_nx   = state == MCYC ? '0 : cnt;
    end else if (state == MCYC) begin
      stall_c  = cnt != '0 ? 5'b00111 : 5'b00000;
      flush_c  = cnt != '0 ? 5'b01000 : 5'b00000;
      cnt_nx   = cnt != '0 ? cnt - CNT_W'(1) : cnt;
      done_c   = cnt == '0;
      state_nx = cnt == '0 ? RUN : MCYC;
    end else if (ex_branch) begin
      // younger instructions are on the wrong path, so their requests are dropped
      flush_c  = 5'b00110;
      redir_c  = 1'b1;
      rpc_c    = ex_branch_tgt;
      state_nx = RUN;
    end else if (ex_mcyc_start) begin
      stall_c  = 5'b00111;
      flush_c  = 5'b01000;
      cnt_nx   = CNT_W'(MCYC_LAT - 1);
      state_nx = MCYC;
    end else begin
      stall_c  = id_loaduse ? 5'b00011 : 5'b00000;
      flush_c  = id_loaduse ? 5'b00100 : 5'b00000;
      state_nx = RUN;
    end
  end
  // all combinational outputs are forced quiet while reset is held
  assign stall       = rst ? stall_c : '0;
  assign flush       = rst ? flush_c : '0;
  assign redirect    = rst & redir_c;
  assign redirect_pc = rst ? rpc_c : '0;
  assign mcyc_done   = rst & done_c;
  assign mcyc_kill   = rst & kill_c;
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall[0] && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (redirect && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_loaduse = 1'b0, ex_branch = 1'b0, ex_mcyc_start = 1'b0, mem_exc = 1'b0;
  logic [31:0] ex_branch_tgt = '0, mem_pc = '0;
  logic [4:0]  stall, flush;
  logic        redirect, mcyc_done, mcyc_kill;
  logic [31:0] redirect_pc, epc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif
  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_loaduse(id_loaduse), .ex_branch(ex_branch),
    .ex_branch_tgt(ex_branch_tgt), .ex_mcyc_start(ex_mcyc_start), .mem_exc(mem_exc),
    .mem_pc(mem_pc), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .mcyc_done(mcyc_done), .mcyc_kill(mcyc_kill), .epc(epc)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_loaduse = 0; ex_branch = 0; ex_mcyc_start = 0; mem_exc = 0;
  endtask

  initial begin
    // outputs must stay zero in reset even with a request present
    id_loaduse = 1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redir", 32'(redirect), 0);
    chk("rst_epc", epc, 0);
    tick();
    rst = 1; idle();
    @(negedge clk);
    chk("idle_stall", 32'(stall), 0);
    chk("idle_flush", 32'(flush), 0);
    // load-use held two cycles
    tick(); id_loaduse = 1;
    @(negedge clk);
    chk("lu1_stall", 32'(stall), 32'h03);
    chk("lu1_flush", 32'(flush), 32'h04);
    tick();
    @(negedge clk);
    chk("lu2_stall", 32'(stall), 32'h03);
    chk("lu2_flush", 32'(flush), 32'h04);
    tick(); idle();
    @(negedge clk);
    chk("lu3_stall", 32'(stall), 0);
    // multi-cycle op: frozen T..T+3, done at T+4
    tick(); ex_mcyc_start = 1; id_loaduse = 1;
    @(negedge clk);
    chk("mc0_stall", 32'(stall), 32'h07);
    chk("mc0_flush", 32'(flush), 32'h08);
    for (int i = 1; i < 4; i++) begin
      tick(); idle();
      if (i == 1) id_loaduse = 1;
      if (i == 2) ex_branch = 1;
      @(negedge clk);
      chk($sformatf("mc%0d_stall", i), 32'(stall), 32'h07);
      chk($sformatf("mc%0d_done", i), 32'(mcyc_done), 0);
      chk($sformatf("mc%0d_redir", i), 32'(redirect), 0);
    end
    tick(); idle();
    @(negedge clk);
    chk("mc4_done", 32'(mcyc_done), 1);
    chk("mc4_stall", 32'(stall), 0);
    tick();
    @(negedge clk);
    chk("mc5_done", 32'(mcyc_done), 0);
    // branch wins over same-cycle load-use and mcyc start
    tick(); ex_branch = 1; ex_branch_tgt = 32'h0000_1040; id_loaduse = 1; ex_mcyc_start = 1;
    @(negedge clk);
    chk("br_redir", 32'(redirect), 1);
    chk("br_pc", redirect_pc, 32'h0000_1040);
    chk("br_flush", 32'(flush), 32'h06);
    chk("br_stall", 32'(stall), 0);
    tick(); idle();
    @(negedge clk);
    chk("br_after_stall", 32'(stall), 0);
    chk("br_after_pc", redirect_pc, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cyc, 6);
    chk("perf_flush", perf_flush_cnt, 1);
`endif
    // exception at T+2 of a multi-cycle op
    tick(); ex_mcyc_start = 1;
    @(negedge clk);
    tick(); idle();
    @(negedge clk);
    tick(); mem_exc = 1; mem_pc = 32'h0000_2000;
    @(negedge clk);
    chk("exc_kill", 32'(mcyc_kill), 1);
    chk("exc_flush", 32'(flush), 32'h1E);
    chk("exc_stall", 32'(stall), 0);
    chk("exc_redir", 32'(redirect), 1);
    chk("exc_pc", redirect_pc, 32'h0000_0080);
    chk("exc_done", 32'(mcyc_done), 0);
    tick(); mem_pc = 32'h0000_3000;
    @(negedge clk);
    chk("exc2_epc", epc, 32'h0000_2000);
    chk("exc2_flush", 32'(flush), 0);
    chk("exc2_redir", 32'(redirect), 0);
    chk("exc2_kill", 32'(mcyc_kill), 0);
    chk("exc2_done", 32'(mcyc_done), 0);
    tick(); idle();
    @(negedge clk);
    chk("exc3_epc", epc, 32'h0000_2000);
    chk("exc3_stall", 32'(stall), 0);
    chk("exc3_done", 32'(mcyc_done), 0);
    // EXC cycle still honours a branch
    tick(); mem_exc = 1; mem_pc = 32'h0000_0044;
    @(negedge clk);
    chk("rexc_kill", 32'(mcyc_kill), 0);
    chk("rexc_flush", 32'(flush), 32'h1E);
    tick(); idle(); ex_branch = 1; ex_branch_tgt = 32'h0000_5000;
    @(negedge clk);
    chk("excbr_pc", redirect_pc, 32'h0000_5000);
    chk("excbr_flush", 32'(flush), 32'h06);
    chk("excbr_epc", epc, 32'h0000_0044);
    // async reset during MCYC aborts without done
    tick(); idle(); ex_mcyc_start = 1;
    @(negedge clk);
    tick(); idle(); rst = 0;
    #1;
    chk("arst_stall", 32'(stall), 0);
    chk("arst_epc", epc, 0);
    chk("arst_kill", 32'(mcyc_kill), 0);
    tick(); rst = 1;
    @(negedge clk);
    chk("arst_run_stall", 32'(stall), 0);
    chk("arst_run_done", 32'(mcyc_done), 0);
    tick();
    @(negedge clk);
    chk("arst_run2_done", 32'(mcyc_done), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
